// File: rtl/interval_timer_ctrl_if.sv
// Interval timer request/reprogram bus.
// The master side is the traffic controller FSM plus the reprogram source.
// The slave side is interval_timer_ctrl.
//   start_timer          master->slave  (re)start a countdown
//   requesting_interval  master->slave  interval select: 00 base, 01 ext, 10 yel, 11 base
//   reprogram            master->slave  write prog_value into the register chosen by prog_sel
//   prog_sel             master->slave  register select: 00 base, 01 ext, 10 yel, 11 none
//   prog_value           master->slave  new interval in seconds
//   expired              slave->master  one-cycle pulse at end of countdown
//   busy                 slave->master  countdown in progress
//   time_left            slave->master  remaining whole seconds
interface interval_timer_ctrl_if #(
   parameter int unsigned PARAM_W = 4
);
   logic               start_timer;
   logic [1:0]         requesting_interval;
   logic               reprogram;
   logic [1:0]         prog_sel;
   logic [PARAM_W-1:0] prog_value;
   logic               expired;
   logic               busy;
   logic [PARAM_W-1:0] time_left;

   modport master (
      output start_timer, requesting_interval, reprogram, prog_sel, prog_value,
      input  expired, busy, time_left
   );

   modport slave (
      input  start_timer, requesting_interval, reprogram, prog_sel, prog_value,
      output expired, busy, time_left
   );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer for the traffic controller FSM.
// Holds the t_base/t_ext/t_yel interval registers, divides clk down to a
// 1 s tick, and on start_timer counts the selected interval down to zero,
// pulsing expired for one cycle at the end.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    interval_timer_ctrl_if slave modport (request, reprogram, status)
module interval_timer_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100000000,
   parameter int unsigned PARAM_W       = 4,
   parameter int unsigned T_BASE_DEF    = 6,
   parameter int unsigned T_EXT_DEF     = 3,
   parameter int unsigned T_YEL_DEF     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   interval_timer_ctrl_if.slave  bus
);

   localparam int unsigned DIV_W = $clog2(TICKS_PER_SEC);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t             state;
   logic [DIV_W-1:0]   div;
   logic [PARAM_W-1:0] t_base;
   logic [PARAM_W-1:0] t_ext;
   logic [PARAM_W-1:0] t_yel;
   logic [PARAM_W-1:0] time_left;
   logic [PARAM_W-1:0] sel_val;
   logic [PARAM_W-1:0] prog_val_nz;
   logic               expired;
   logic               busy;

   assign bus.expired   = expired;
   assign bus.busy      = busy;
   assign bus.time_left = time_left;

   always_comb begin
      sel_val = t_base;
      case (bus.requesting_interval)
         2'b01:   sel_val = t_ext;
         2'b10:   sel_val = t_yel;
         default: sel_val = t_base;
      endcase
   end

   // A zero interval would never expire, so it is stored as 1 s.
   assign prog_val_nz = (bus.prog_value == '0) ? PARAM_W'(1) : bus.prog_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div       <= '0;
         time_left <= '0;
         expired   <= 1'b0;
         busy      <= 1'b0;
         t_base    <= PARAM_W'(T_BASE_DEF);
         t_ext     <= PARAM_W'(T_EXT_DEF);
         t_yel     <= PARAM_W'(T_YEL_DEF);
      end else begin
         expired <= 1'b0;

         // Register writes land at this edge; a start on the same edge
         // still loads the value held before it.
         if (bus.reprogram) begin
            case (bus.prog_sel)
               2'b00:   t_base <= prog_val_nz;
               2'b01:   t_ext  <= prog_val_nz;
               2'b10:   t_yel  <= prog_val_nz;
               default: ;
            endcase
         end

         // Start has priority over the final tick: the old count is dropped
         // without a pulse.
         if (bus.start_timer) begin
            state     <= COUNT;
            div       <= '0;
            time_left <= sel_val;
            busy      <= 1'b1;
         end else if (state == COUNT) begin
            if (div == DIV_LAST) begin
               div <= '0;
               if (time_left <= PARAM_W'(1)) begin
                  time_left <= '0;
                  busy      <= 1'b0;
                  expired   <= 1'b1;
                  state     <= IDLE;
               end else begin
                  time_left <= time_left - PARAM_W'(1);
               end
            end else begin
               div <= div + DIV_W'(1);
            end
         end else begin
            div       <= '0;
            time_left <= '0;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   interval_timer_ctrl_if #(.PARAM_W(4)) bus ();

   interval_timer_ctrl #(
      .TICKS_PER_SEC (4),
      .PARAM_W       (4),
      .T_BASE_DEF    (6),
      .T_EXT_DEF     (3),
      .T_YEL_DEF     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Start pulse sampled at the next edge (E0); returns 1 unit after E0.
   task automatic pulse_start(input logic [1:0] sel);
      bus.start_timer         = 1'b1;
      bus.requesting_interval = sel;
      step();
      bus.start_timer         = 1'b0;
   endtask

   task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
      bus.reprogram  = 1'b1;
      bus.prog_sel   = sel;
      bus.prog_value = val;
      step();
      bus.reprogram  = 1'b0;
   endtask

   // Watches 'window' edges; reports the edge index of the first expired
   // pulse (0 if none), pulse-cycle count, and busy/time_left at that cycle.
   task automatic observe(input int window, output int first, output int pulses,
                          output logic busy_at, output logic [3:0] tl_at);
      first   = 0;
      pulses  = 0;
      busy_at = 1'bx;
      tl_at   = 'x;
      for (int c = 1; c <= window; c++) begin
         step();
         if (bus.expired === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first   = c;
               busy_at = bus.busy;
               tl_at   = bus.time_left;
            end
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (bus.expired !== 1'b0 || bus.busy !== 1'b0 || bus.time_left !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: got exp=%b busy=%b tl=%0d want 0 0 0",
                  bus.expired, bus.busy, bus.time_left);
      end
   endtask

   task automatic test_base_count();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      pulse_start(2'b00);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.time_left !== 4'd6) begin
         n_err++;
         $display("FAIL base_load: got busy=%b tl=%0d want 1 6", bus.busy, bus.time_left);
      end
      step();
      step();
      step();
      step();
      n_cmp++;
      if (bus.time_left !== 4'd5) begin
         n_err++;
         $display("FAIL base_first_tick: got tl=%0d want 5", bus.time_left);
      end
      observe(26, first, pulses, b, tl);
      n_cmp++;
      if (first !== 20 || pulses !== 1) begin
         n_err++;
         $display("FAIL base_expire: got at=%0d pulses=%0d want at=24 pulses=1",
                  first + 4, pulses);
      end
      n_cmp++;
      if (b !== 1'b0 || tl !== 4'd0) begin
         n_err++;
         $display("FAIL base_expire_status: got busy=%b tl=%0d want 0 0", b, tl);
      end
   endtask

   task automatic test_reprogram();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      do_reprogram(2'b10, 4'd5);
      pulse_start(2'b10);
      n_cmp++;
      if (bus.time_left !== 4'd5) begin
         n_err++;
         $display("FAIL prog_yel_load: got tl=%0d want 5", bus.time_left);
      end
      observe(26, first, pulses, b, tl);
      n_cmp++;
      if (first !== 20 || pulses !== 1) begin
         n_err++;
         $display("FAIL prog_yel_expire: got at=%0d pulses=%0d want 20 1", first, pulses);
      end
      do_reprogram(2'b01, 4'd0);
      pulse_start(2'b01);
      n_cmp++;
      if (bus.time_left !== 4'd1) begin
         n_err++;
         $display("FAIL prog_zero_load: got tl=%0d want 1", bus.time_left);
      end
      observe(10, first, pulses, b, tl);
      n_cmp++;
      if (first !== 4 || pulses !== 1) begin
         n_err++;
         $display("FAIL prog_zero_expire: got at=%0d pulses=%0d want 4 1", first, pulses);
      end
   endtask

   task automatic test_restart();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      pulse_start(2'b00);
      observe(9, first, pulses, b, tl);
      pulse_start(2'b10);
      n_cmp++;
      if (pulses !== 0 || bus.time_left !== 4'd2 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL restart_load: got pulses=%0d tl=%0d busy=%b want 0 2 1",
                  pulses, bus.time_left, bus.busy);
      end
      observe(30, first, pulses, b, tl);
      n_cmp++;
      if (first !== 8 || pulses !== 1) begin
         n_err++;
         $display("FAIL restart_expire: got at=%0d pulses=%0d want 8 1", first, pulses);
      end
   endtask

   task automatic test_start_on_final_tick();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      pulse_start(2'b10);
      observe(7, first, pulses, b, tl);
      pulse_start(2'b01);
      n_cmp++;
      if (pulses !== 0 || bus.expired !== 1'b0 || bus.time_left !== 4'd3 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL final_tick_start: got pulses=%0d exp=%b tl=%0d busy=%b want 0 0 3 1",
                  pulses, bus.expired, bus.time_left, bus.busy);
      end
      observe(20, first, pulses, b, tl);
      n_cmp++;
      if (first !== 12 || pulses !== 1) begin
         n_err++;
         $display("FAIL final_tick_expire: got at=%0d pulses=%0d want 12 1", first, pulses);
      end
   endtask

   task automatic test_reset_mid_count();
      int first, pulses, p2;
      logic b;
      logic [3:0] tl;
      apply_reset();
      do_reprogram(2'b10, 4'd9);
      pulse_start(2'b00);
      observe(11, first, pulses, b, tl);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.time_left !== 4'd0 || bus.expired !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_state: got busy=%b tl=%0d exp=%b want 0 0 0",
                  bus.busy, bus.time_left, bus.expired);
      end
      observe(20, first, p2, b, tl);
      n_cmp++;
      if (pulses + p2 !== 0) begin
         n_err++;
         $display("FAIL mid_reset_no_pulse: got pulses=%0d want 0", pulses + p2);
      end
      pulse_start(2'b10);
      observe(20, first, pulses, b, tl);
      n_cmp++;
      if (first !== 8 || pulses !== 1) begin
         n_err++;
         $display("FAIL mid_reset_default: got at=%0d pulses=%0d want 8 1", first, pulses);
      end
   endtask

   task automatic test_sel_11();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      pulse_start(2'b11);
      n_cmp++;
      if (bus.time_left !== 4'd6) begin
         n_err++;
         $display("FAIL sel11_load: got tl=%0d want 6", bus.time_left);
      end
      observe(30, first, pulses, b, tl);
      n_cmp++;
      if (first !== 24 || pulses !== 1) begin
         n_err++;
         $display("FAIL sel11_expire: got at=%0d pulses=%0d want 24 1", first, pulses);
      end
      do_reprogram(2'b11, 4'd1);
      pulse_start(2'b00);
      n_cmp++;
      if (bus.time_left !== 4'd6) begin
         n_err++;
         $display("FAIL prog_sel11_base: got tl=%0d want 6", bus.time_left);
      end
      observe(30, first, pulses, b, tl);
      n_cmp++;
      if (first !== 24 || pulses !== 1) begin
         n_err++;
         $display("FAIL prog_sel11_expire: got at=%0d pulses=%0d want 24 1", first, pulses);
      end
   endtask

   task automatic test_back_to_back();
      int first, pulses;
      logic b;
      logic [3:0] tl;
      apply_reset();
      pulse_start(2'b10);
      observe(8, first, pulses, b, tl);
      n_cmp++;
      if (first !== 8 || pulses !== 1 || bus.expired !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first: got at=%0d pulses=%0d exp=%b want 8 1 1",
                  first, pulses, bus.expired);
      end
      pulse_start(2'b10);
      n_cmp++;
      if (bus.expired !== 1'b0 || bus.busy !== 1'b1 || bus.time_left !== 4'd2) begin
         n_err++;
         $display("FAIL b2b_restart: got exp=%b busy=%b tl=%0d want 0 1 2",
                  bus.expired, bus.busy, bus.time_left);
      end
      observe(20, first, pulses, b, tl);
      n_cmp++;
      if (first !== 8 || pulses !== 1) begin
         n_err++;
         $display("FAIL b2b_second: got at=%0d pulses=%0d want 8 1", first, pulses);
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.time_left !== 4'd0) begin
         n_err++;
         $display("FAIL idle_hold: got busy=%b tl=%0d want 0 0", bus.busy, bus.time_left);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.start_timer         = 1'b0;
      bus.requesting_interval = 2'b00;
      bus.reprogram           = 1'b0;
      bus.prog_sel            = 2'b11;
      bus.prog_value          = 4'd0;
      step();
      test_reset();
      test_base_count();
      test_reprogram();
      test_restart();
      test_start_on_final_tick();
      test_reset_mid_count();
      test_sel_11();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
